board_win_scanner: RTL and testbench

Sequential reader of the 512-bit Gomoku board vector (16×16 cells, 2 bits each, cell (x,y) at bit offset x*2 + y*32). It sits between the board-write logic and the display path. On request it snapshots the board and scans every cell and direction for five equal stones in a row, then reports the game status. The result drives `gaming_status`, plus the winning line's origin and direction for highlighting.

---
 rtl/fiveson_pkg.sv | 62 ++++++
 rtl/run_matcher.sv | 41 ++++
 rtl/board_win_scanner.sv | 152 +++++++++++++++
 tb/tb_board_win_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fiveson_pkg.sv
// Shared definitions for the Gomoku board scanner: cell, status and direction
// encodings plus the board bit-offset helper.
package fiveson_pkg;

  localparam int DIM     = 16;
  localparam int CELL_W  = 2;
  localparam int RUN     = 5;
  localparam int COORD_W = $clog2(DIM);
  localparam int OFF_W   = $clog2(DIM * DIM * CELL_W);

  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam logic [1:0] CELL_EMPTY = 2'b11;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_P1   = 2'b01;
  localparam logic [1:0] ST_P2   = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;

  typedef enum logic [1:0] {
    DIR_E  = 2'd0,
    DIR_S  = 2'd1,
    DIR_SE = 2'd2,
    DIR_SW = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;

  function automatic int dir_dx(input logic [1:0] d);
    case (d)
      DIR_E:   return 32'sd1;
      DIR_S:   return 32'sd0;
      DIR_SE:  return 32'sd1;
      DIR_SW:  return -32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic int dir_dy(input logic [1:0] d);
    case (d)
      DIR_E:   return 32'sd0;
      DIR_S:   return 32'sd1;
      DIR_SE:  return 32'sd1;
      DIR_SW:  return 32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic logic [OFF_W-1:0] cell_off(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return OFF_W'(x) * OFF_W'(CELL_W) + OFF_W'(y) * OFF_W'(DIM * CELL_W);
  endfunction

  function automatic logic cell_is_player(input logic [1:0] c);
    return (c == CELL_P1) || (c == CELL_P2);
  endfunction

endpackage

// File: rtl/run_matcher.sv
// Combinational check of one (origin, direction) pair: true when RUN cells
// starting at the origin stay on the board and all hold the same player code.
module run_matcher
  import fiveson_pkg::*;
#(
  parameter int RUN_P = RUN
) (
  input  logic [DIM*DIM*CELL_W-1:0] snap,
  input  logic [COORD_W-1:0]        org_x,
  input  logic [COORD_W-1:0]        org_y,
  input  logic [1:0]                dir,
  output logic                      match,
  output logic [1:0]                player
);

  // Walk the run; any cell off the board or differing from the origin kills the match.
  always_comb begin
    int dx;
    int dy;
    int cx;
    int cy;
    dx     = dir_dx(dir);
    dy     = dir_dy(dir);
    cx     = 32'sd0;
    cy     = 32'sd0;
    player = snap[cell_off(org_x, org_y) +: CELL_W];
    match  = cell_is_player(player);
    for (int i = 0; i < RUN_P; i++) begin
      cx = int'(org_x) + i * dx;
      cy = int'(org_y) + i * dy;
      if (cx < 32'sd0 || cx >= DIM || cy < 32'sd0 || cy >= DIM) begin
        match = 1'b0;
      end else if (snap[cell_off(cx[COORD_W-1:0], cy[COORD_W-1:0]) +: CELL_W] != player) begin
        match = 1'b0;
      end else begin
        match = match;
      end
    end
  end

endmodule

// File: rtl/board_win_scanner.sv
// Snapshots the board on request and scans every origin/direction pair, one
// per cycle, reporting the first five-in-a-row or playing/draw status.
module board_win_scanner #(
  parameter int DIM = 16,
  parameter int RUN = 5
) (
  input  logic                     Clck,
  input  logic                     Reset,
  input  logic [DIM*DIM*2-1:0]     board,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status,
  output logic [$clog2(DIM)-1:0]   win_x,
  output logic [$clog2(DIM)-1:0]   win_y,
  output logic [1:0]               win_dir
);
  import fiveson_pkg::*;

  localparam int XW    = $clog2(DIM);
  localparam int IDX_W = 2 + 2 * XW;
  localparam int BW    = DIM * DIM * 2;

  scan_state_e       state_q, state_d;
  logic [BW-1:0]     snap_q, snap_d;
  logic              full_q, full_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [XW-1:0]     win_x_q, win_x_d;
  logic [XW-1:0]     win_y_q, win_y_d;
  logic [1:0]        win_dir_q, win_dir_d;

  logic              board_full_s;
  logic              match_s;
  logic [1:0]        player_s;
  logic [XW-1:0]     cur_x_s;
  logic [XW-1:0]     cur_y_s;
  logic [1:0]        cur_dir_s;

  assign cur_dir_s = idx_q[1:0];
  assign cur_x_s   = idx_q[2 +: XW];
  assign cur_y_s   = idx_q[2 + XW +: XW];

  run_matcher #(.RUN_P(RUN)) u_matcher (
    .snap   (snap_q),
    .org_x  (cur_x_s),
    .org_y  (cur_y_s),
    .dir    (cur_dir_s),
    .match  (match_s),
    .player (player_s)
  );

  // Codes 11 and 00 are both empty, i.e. a cell whose two bits agree.
  always_comb begin
    board_full_s = 1'b1;
    for (int i = 0; i < DIM * DIM; i++) begin
      if (board[i*2+1] == board[i*2]) begin
        board_full_s = 1'b0;
      end else begin
        board_full_s = board_full_s;
      end
    end
  end

  // Next-state and result logic for IDLE -> SCAN -> DONE.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    full_d    = full_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    status_d  = status_q;
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
    win_dir_d = win_dir_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = board;
          full_d  = board_full_s;
          idx_d   = {IDX_W{1'b0}};
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (match_s) begin
          status_d  = player_s;
          win_x_d   = cur_x_s;
          win_y_d   = cur_y_s;
          win_dir_d = cur_dir_s;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (idx_q == {IDX_W{1'b1}}) begin
          status_d  = full_q ? ST_DRAW : ST_PLAY;
          win_x_d   = {XW{1'b0}};
          win_y_d   = {XW{1'b0}};
          win_dir_d = 2'b00;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SCAN);
  end

  // State and output registers.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      snap_q    <= {BW{1'b0}};
      full_q    <= 1'b0;
      idx_q     <= {IDX_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_PLAY;
      win_x_q   <= {XW{1'b0}};
      win_y_q   <= {XW{1'b0}};
      win_dir_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      full_q    <= full_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      win_dir_q <= win_dir_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign status  = status_q;
  assign win_x   = win_x_q;
  assign win_y   = win_y_q;
  assign win_dir = win_dir_q;

endmodule

// File: tb/tb_board_win_scanner.sv
// Directed bench for board_win_scanner: hand-built boards with hand-computed
// result, origin and done latency.
module tb_board_win_scanner;

  logic         clk;
  logic         rst_n;
  logic [511:0] board;
  logic         start;
  logic         busy;
  logic         done;
  logic [1:0]   status;
  logic [3:0]   win_x;
  logic [3:0]   win_y;
  logic [1:0]   win_dir;

  int           errors;
  int           checks;
  int           dcyc;
  int           bcnt;
  int           dcnt;
  logic [511:0] alt_board;
  logic [511:0] b1;
  logic [511:0] b2;
  logic [511:0] b3;
  logic [511:0] b4;

  board_win_scanner #(.DIM(16), .RUN(5)) dut (
    .Clck    (clk),
    .Reset   (rst_n),
    .board   (board),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .status  (status),
    .win_x   (win_x),
    .win_y   (win_y),
    .win_dir (win_dir)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] put(input logic [511:0] b, input int x, input int y,
                                       input logic [1:0] c);
    b[x*2 + y*32 +: 2] = c;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one start and watch the scan; poke>0 pulses start and swaps the board mid-scan.
  task automatic scan(input logic [511:0] b, input int poke,
                      output int dc, output int bc, output int nc);
    int n;
    @(negedge clk);
    board = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n  = 0;
    dc = -1;
    bc = 0;
    nc = 0;
    @(negedge clk);
    if (busy === 1'b1) bc++;
    if (done === 1'b1) nc++;
    while (n < 1100 && (dc < 0 || n < dc + 4)) begin
      @(posedge clk);
      n++;
      #1;
      if (n == poke) begin
        start = 1'b1;
        board = alt_board;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        nc++;
        if (dc < 0) dc = n;
      end
    end
  endtask

  task automatic check_result(input string tag, input int exp_dc, input logic [1:0] exp_st,
                              input int ex, input int ey, input int ed);
    check({tag, "_done_cycle"}, dcyc, exp_dc);
    check({tag, "_busy_cycles"}, bcnt, exp_dc);
    check({tag, "_done_pulses"}, dcnt, 1);
    check({tag, "_status"}, {30'b0, status}, {30'b0, exp_st});
    check({tag, "_win_x"}, {28'b0, win_x}, ex);
    check({tag, "_win_y"}, {28'b0, win_y}, ey);
    check({tag, "_win_dir"}, {30'b0, win_dir}, ed);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    board  = '1;

    b1 = '1;
    for (int x = 4; x <= 8; x++) b1 = put(b1, x, 6, 2'b01);
    b2 = '1;
    for (int i = 0; i < 5; i++) b2 = put(b2, 10 - i, 2 + i, 2'b10);
    b3 = '1;
    for (int x = 12; x <= 15; x++) b3 = put(b3, x, 3, 2'b01);
    b3 = put(b3, 0, 4, 2'b01);
    for (int y = 0; y <= 3; y++) b3 = put(b3, 2, y, 2'b01);
    b4 = '1;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        b4 = put(b4, x, y, ((((x >> 1) + y) % 2) == 0) ? 2'b01 : 2'b10);
    alt_board = '1;
    for (int x = 0; x < 5; x++) alt_board = put(alt_board, x, 0, 2'b10);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_status", {30'b0, status}, 0);
    check("rst_win_x", {28'b0, win_x}, 0);
    check("rst_win_y", {28'b0, win_y}, 0);
    check("rst_win_dir", {30'b0, win_dir}, 0);
    rst_n = 1'b1;

    // Horizontal P1 run at (4..8,6): idx 400.
    scan(b1, 0, dcyc, bcnt, dcnt);
    check_result("p1_row", 401, 2'b01, 4, 6, 0);

    // SW diagonal P2 from (10,2): idx (2*16+10)*4+3 = 171.
    scan(b2, 0, dcyc, bcnt, dcnt);
    check_result("p2_sw", 172, 2'b10, 10, 2, 3);

    // Edge run must not wrap; vertical four is short: playing.
    scan(b3, 0, dcyc, bcnt, dcnt);
    check_result("nowrap", 1024, 2'b00, 0, 0, 0);

    // Full board with no run of five: draw.
    scan(b4, 0, dcyc, bcnt, dcnt);
    check_result("draw", 1024, 2'b11, 0, 0, 0);

    // Mid-scan start pulse and board change are ignored.
    scan(b1, 50, dcyc, bcnt, dcnt);
    check_result("snapshot", 401, 2'b01, 4, 6, 0);

    // Reset at cycle 200 of a scan aborts it without a done pulse.
    @(negedge clk);
    board = b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (199) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_status", {30'b0, status}, 0);
    check("midrst_win_x", {28'b0, win_x}, 0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("midrst_quiet", dcnt, 0);

    scan(b2, 0, dcyc, bcnt, dcnt);
    check_result("after_rst", 172, 2'b10, 10, 2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
